bsg_burst_len_sequencer: RTL and testbench

- Upstream controller for a bsg_counter_set_down instance; drives that counter's set_i/val_i/down_i and reads back count_r_o.
- Accepts burst-length requests on a valid/ready interface and buffers them in a small queue.
- Loads each length into the down-counter, then issues one beat per counter decrement on a valid/yumi interface.
- Signals completion of each burst.

---
 rtl/bsg_burst_len_sequencer.sv | 156 +++++++++++++++
 tb/tb_bsg_burst_len_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_burst_len_sequencer.sv
// rtl/bsg_burst_len_sequencer.sv - queues burst lengths and sequences beats through an external set/down counter
// Optional feature macro: BSG_BURST_SEQ_BACK2BACK_EN (reload the counter on the last beat for zero-bubble bursts)
module bsg_burst_len_sequencer #(
  parameter int width_p = 16,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               len_v_i,
  input  logic [width_p-1:0] len_i,
  output logic               len_ready_o,
  output logic               beat_v_o,
  input  logic               beat_yumi_i,
  output logic               last_o,
  output logic               done_o,
  output logic               set_o,
  output logic [width_p-1:0] val_o,
  output logic               down_o,
  input  logic [width_p-1:0] count_i,
  output logic               busy_o
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [width_p-1:0]  r_mem [els_p];
  logic [ptr_w_lp-1:0] r_rd_ptr;
  logic [ptr_w_lp-1:0] r_wr_ptr;
  logic [cnt_w_lp-1:0] r_used;

  logic               w_empty;
  logic               w_full;
  logic               w_enq;
  logic               w_deq;
  logic [width_p-1:0] w_head;
  logic               w_head_zero;
  logic               w_cnt_nz;
  logic               w_cnt_one;
  logic               w_set;
  logic               w_down;
  logic               w_beat_v;
  logic               w_last;
  logic               w_done;

  function automatic logic [ptr_w_lp-1:0] next_ptr(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  assign w_empty     = (r_used == '0);
  assign w_full      = (r_used == cnt_w_lp'(els_p));
  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_zero = (w_head == '0);
  // Full blocks enqueue even when a dequeue happens in the same cycle.
  assign w_enq       = len_v_i & ~w_full;

  assign w_cnt_nz  = (count_i != '0);
  assign w_cnt_one = (count_i == width_p'(1));

  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_mem[r_wr_ptr] <= len_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_used   <= '0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (w_deq) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      case ({w_enq, w_deq})
        2'b10:   r_used <= r_used + cnt_w_lp'(1);
        2'b01:   r_used <= r_used - cnt_w_lp'(1);
        default: r_used <= r_used;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_deq       = 1'b0;
    w_set       = 1'b0;
    w_down      = 1'b0;
    w_beat_v    = 1'b0;
    w_last      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_deq = 1'b1;
          if (w_head_zero) begin
            w_done = 1'b1;
          end else begin
            w_set       = 1'b1;
            w_state_nxt = RUN;
          end
        end
      end
      RUN: begin
        // Gating on a non-zero count keeps the counter from ever wrapping.
        w_beat_v = w_cnt_nz;
        w_last   = w_cnt_nz & w_cnt_one;
        w_down   = beat_yumi_i & w_cnt_nz;
        if (!w_cnt_nz) begin
          w_state_nxt = IDLE;
        end else if (beat_yumi_i && w_last) begin
          w_done = 1'b1;
`ifdef BSG_BURST_SEQ_BACK2BACK_EN
          if (!w_empty && !w_head_zero) begin
            w_set  = 1'b1;
            w_down = 1'b0;
            w_deq  = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
`else
          w_state_nxt = IDLE;
`endif
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign len_ready_o = ~w_full;
  assign beat_v_o    = w_beat_v;
  assign last_o      = w_last;
  assign done_o      = w_done;
  assign set_o       = w_set;
  assign val_o       = w_set ? w_head : '0;
  assign down_o      = w_down;
  assign busy_o      = (r_state != IDLE) | ~w_empty;

endmodule

// File: tb/tb_bsg_burst_len_sequencer.sv
// tb/tb_bsg_burst_len_sequencer.sv - directed bench for bsg_burst_len_sequencer with a set/down counter model
module tb_bsg_burst_len_sequencer;

  logic        clk_i;
  logic        reset_i;
  logic        len_v_i;
  logic [15:0] len_i;
  logic        len_ready_o;
  logic        beat_v_o;
  logic        beat_yumi_i;
  logic        last_o;
  logic        done_o;
  logic        set_o;
  logic [15:0] val_o;
  logic        down_o;
  logic [15:0] r_count;
  logic        busy_o;

  int n_tests = 0;
  int n_fail  = 0;
  int beat_total = 0;
  int done_total = 0;
  int bb;
  int bd;
  int k;
  int d_yumi [7] = '{1, 0, 0, 1, 1, 0, 1};
  int d_cnt  [7] = '{4, 3, 3, 3, 2, 1, 1};
  logic [4:0] f_exp;

  bsg_burst_len_sequencer #(.width_p(16), .els_p(2)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .len_v_i     (len_v_i),
    .len_i       (len_i),
    .len_ready_o (len_ready_o),
    .beat_v_o    (beat_v_o),
    .beat_yumi_i (beat_yumi_i),
    .last_o      (last_o),
    .done_o      (done_o),
    .set_o       (set_o),
    .val_o       (val_o),
    .down_o      (down_o),
    .count_i     (r_count),
    .busy_o      (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // bsg_counter_set_down stand-in: set wins over down
  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i)     r_count <= '0;
    else if (set_o)  r_count <= val_o;
    else if (down_o) r_count <= r_count - 16'd1;
  end

  always @(posedge clk_i) begin
    if (!reset_i) begin
      if (beat_v_o && beat_yumi_i) beat_total <= beat_total + 1;
      if (done_o) done_total <= done_total + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [15:0] l, input logic y);
    @(negedge clk_i);
    len_v_i     = v;
    len_i       = l;
    beat_yumi_i = y;
    #1;
  endtask

  initial begin
    reset_i = 1'b1; len_v_i = 1'b0; len_i = '0; beat_yumi_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_ready", 32'(len_ready_o), 1);
    chk("rst_beat_v", 32'(beat_v_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_set", 32'(set_o), 0);
    chk("rst_val", 32'(val_o), 0);
    chk("rst_down", 32'(down_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_last", 32'(last_o), 0);
    @(negedge clk_i);
    reset_i = 1'b0;

    // single burst of 3
    bb = beat_total; bd = done_total;
    step(1'b1, 16'd3, 1'b0);
    chk("b_ready", 32'(len_ready_o), 1);
    chk("b_idle_set", 32'(set_o), 0);
    step(1'b0, 16'd0, 1'b0);
    chk("b_set", 32'(set_o), 1);
    chk("b_val", 32'(val_o), 3);
    chk("b_down_on_set", 32'(down_o), 0);
    chk("b_no_beat_on_set", 32'(beat_v_o), 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 16'd0, 1'b1);
      chk("b_beat_v", 32'(beat_v_o), 1);
      chk("b_count", 32'(r_count), 32'(3 - i));
      chk("b_last", 32'(last_o), 32'(i == 2));
      chk("b_done", 32'(done_o), 32'(i == 2));
    end
    step(1'b0, 16'd0, 1'b0);
    chk("b_idle_beat_v", 32'(beat_v_o), 0);
    chk("b_idle_busy", 32'(busy_o), 0);
    chk("b_count_zero", 32'(r_count), 0);
    chk("b_beats", 32'(beat_total - bb), 3);
    chk("b_dones", 32'(done_total - bd), 1);

    // zero-length then length 2
    bb = beat_total; bd = done_total;
    step(1'b1, 16'd0, 1'b0);
    step(1'b1, 16'd2, 1'b0);
    chk("c_zero_done", 32'(done_o), 1);
    chk("c_zero_set", 32'(set_o), 0);
    chk("c_zero_beat", 32'(beat_v_o), 0);
    step(1'b0, 16'd0, 1'b0);
    chk("c_set", 32'(set_o), 1);
    chk("c_val", 32'(val_o), 2);
    chk("c_no_done", 32'(done_o), 0);
    step(1'b0, 16'd0, 1'b1);
    chk("c_count2", 32'(r_count), 2);
    step(1'b0, 16'd0, 1'b1);
    chk("c_last", 32'(last_o), 1);
    chk("c_done", 32'(done_o), 1);
    step(1'b0, 16'd0, 1'b0);
    chk("c_beats", 32'(beat_total - bb), 2);
    chk("c_dones", 32'(done_total - bd), 2);
    chk("c_busy", 32'(busy_o), 0);

    // backpressure on length 4
    bb = beat_total;
    step(1'b1, 16'd4, 1'b0);
    step(1'b0, 16'd0, 1'b0);
    chk("d_val", 32'(val_o), 4);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 16'd0, d_yumi[i][0]);
      chk("d_beat_v", 32'(beat_v_o), 1);
      chk("d_count", 32'(r_count), 32'(d_cnt[i]));
      chk("d_last", 32'(last_o), 32'(i >= 5));
      chk("d_down", 32'(down_o), 32'(d_yumi[i]));
    end
    step(1'b0, 16'd0, 1'b0);
    chk("d_beats", 32'(beat_total - bb), 4);
    chk("d_busy", 32'(busy_o), 0);

    // queue full: 7,7,7 with a stray request held while full
    bb = beat_total; bd = done_total;
    step(1'b1, 16'd7, 1'b0);
    step(1'b1, 16'd7, 1'b0);
    chk("e_set", 32'(set_o), 1);
    step(1'b1, 16'd7, 1'b1);
    chk("e_beat_v", 32'(beat_v_o), 1);
    chk("e_ready_one", 32'(len_ready_o), 1);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 16'd5, 1'b1);
      chk("e_full", 32'(len_ready_o), 0);
    end
    step(1'b0, 16'd0, 1'b1);
    k = 0;
    while (busy_o && k < 100) begin
      step(1'b0, 16'd0, 1'b1);
      k++;
    end
    chk("e_drain", 32'(busy_o), 0);
    step(1'b0, 16'd0, 1'b0);
    chk("e_beats", 32'(beat_total - bb), 21);
    chk("e_dones", 32'(done_total - bd), 3);

    // two bursts of 2: bubble versus back-to-back
`ifdef BSG_BURST_SEQ_BACK2BACK_EN
    f_exp = 5'b11110;
`else
    f_exp = 5'b11011;
`endif
    step(1'b1, 16'd2, 1'b0);
    step(1'b1, 16'd2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 16'd0, 1'b1);
      chk("f_beat_pattern", 32'(beat_v_o), 32'(f_exp[4 - i]));
    end
    step(1'b0, 16'd0, 1'b0);
    chk("f_busy", 32'(busy_o), 0);

    // asynchronous reset mid-burst
    step(1'b1, 16'd5, 1'b0);
    step(1'b0, 16'd0, 1'b0);
    step(1'b0, 16'd0, 1'b1);
    step(1'b0, 16'd0, 1'b1);
    @(negedge clk_i);
    beat_yumi_i = 1'b0;
    #1;
    chk("g_running", 32'(beat_v_o), 1);
    #1;
    reset_i = 1'b1;
    #1;
    chk("g_beat_v", 32'(beat_v_o), 0);
    chk("g_busy", 32'(busy_o), 0);
    chk("g_ready", 32'(len_ready_o), 1);
    chk("g_set", 32'(set_o), 0);
    @(negedge clk_i);
    reset_i = 1'b0;
    bb = beat_total;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 16'd0, 1'b0);
      chk("g_quiet", 32'(beat_v_o), 0);
    end
    chk("g_beats", 32'(beat_total - bb), 0);
    chk("g_busy_after", 32'(busy_o), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
